// File: rtl/pause_arbiter.sv
// Pause sequencer and work-RAM arbiter between the running core and the high-score engine.
// Build option: define PAUSE_DIM_EN to build the long-user-pause screen-dim counter.
module pause_arbiter #(
  parameter logic [31:0] DIM_CYCLES  = 32'h0ABA9500,
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter int unsigned GUARD       = 4
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       btn_pause,
  input  logic       osd_open,
  input  logic       osd_pause_en,
  input  logic       hs_req,
  input  logic       halt_ack,
  output logic       pause,
  output logic       hs_grant,
  output logic       dim_video,
  output logic       user_paused,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_RUN     = 3'd0,
    S_DRAIN   = 3'd1,
    S_HALT    = 3'd2,
    S_HS      = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] tmo;
  logic [3:0] gcnt;
  logic       btn_prev;
  logic       pause_src;

  assign pause_src = user_paused | (osd_open & osd_pause_en) | hs_req;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      btn_prev    <= 1'b1;
      user_paused <= 1'b0;
    end else begin
      btn_prev <= btn_pause;
      if (btn_pause & ~btn_prev)
        user_paused <= ~user_paused;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:     if (pause_src) state_d = S_DRAIN;
      S_DRAIN: begin
        if (!pause_src)                          state_d = S_RELEASE;
        else if (halt_ack)                       state_d = S_HALT;
        else if (tmo == 8'(ACK_TIMEOUT - 1))     state_d = S_HALT;
      end
      S_HALT: begin
        if (hs_req)          state_d = S_HS;
        else if (!pause_src) state_d = S_RELEASE;
      end
      S_HS:      if (!hs_req) state_d = S_HALT;
      S_RELEASE: begin
        if (pause_src)                      state_d = S_DRAIN;
        else if (gcnt == 4'(GUARD - 1))     state_d = S_RUN;
      end
      default:   state_d = S_RUN;
    endcase
  end

  // Counters run only in their own state, so they are zero on every entry.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= S_RUN;
      tmo     <= '0;
      gcnt    <= '0;
    end else begin
      state_q <= state_d;
      tmo     <= (state_q == S_DRAIN)   ? tmo + 8'd1  : '0;
      gcnt    <= (state_q == S_RELEASE) ? gcnt + 4'd1 : '0;
    end
  end

  assign pause    = (state_q != S_RUN);
  assign hs_grant = (state_q == S_HS);
  assign state    = state_q;

`ifdef PAUSE_DIM_EN
  logic [31:0] dimcnt;

  always_ff @(posedge clk_sys) begin
    if (reset || !user_paused)
      dimcnt <= '0;
    else if (dimcnt < DIM_CYCLES)
      dimcnt <= dimcnt + 32'd1;
  end

  assign dim_video = (dimcnt >= DIM_CYCLES);
`else
  logic unused_dim_cycles;
  assign unused_dim_cycles = ^DIM_CYCLES;
  assign dim_video         = 1'b0;
`endif

endmodule

// File: tb/tb_pause_arbiter.sv
// Randomized and directed bench for pause_arbiter against a cycle-level reference model.
module tb_pause_arbiter;

  localparam int TB_DIM   = 100;
  localparam int TB_ACK   = 16;
  localparam int TB_GUARD = 4;
`ifdef PAUSE_DIM_EN
  localparam bit DIM_ON = 1'b1;
`else
  localparam bit DIM_ON = 1'b0;
`endif

  localparam int RUN = 0, DRAIN = 1, HALT = 2, HS = 3, RELEASE = 4;

  logic       clk_sys = 1'b0;
  logic       reset = 1'b1;
  logic       btn_pause = 1'b1;
  logic       osd_open = 1'b0;
  logic       osd_pause_en = 1'b0;
  logic       hs_req = 1'b0;
  logic       halt_ack = 1'b1;
  logic       pause, hs_grant, dim_video, user_paused;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  pause_arbiter #(
    .DIM_CYCLES (32'(TB_DIM)),
    .ACK_TIMEOUT(TB_ACK),
    .GUARD      (TB_GUARD)
  ) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .btn_pause   (btn_pause),
    .osd_open    (osd_open),
    .osd_pause_en(osd_pause_en),
    .hs_req      (hs_req),
    .halt_ack    (halt_ack),
    .pause       (pause),
    .hs_grant    (hs_grant),
    .dim_video   (dim_video),
    .user_paused (user_paused),
    .state       (state)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: mode plus elapsed drain cycles, remaining guard cycles and paused time.
  int m_mode = RUN;
  int m_drain_elapsed = 0;
  int m_guard_left = 0;
  int m_paused_cycles = 0;
  bit m_user = 1'b0;
  bit m_btn_prev = 1'b1;

  always @(posedge clk_sys) begin
    bit want_pause;
    if (reset) begin
      m_mode = RUN; m_user = 1'b0; m_btn_prev = 1'b1;
      m_paused_cycles = 0; m_drain_elapsed = 0; m_guard_left = 0;
    end else begin
      want_pause = m_user || (osd_open && osd_pause_en) || hs_req;
      case (m_mode)
        RUN: if (want_pause) begin m_mode = DRAIN; m_drain_elapsed = 0; end
        DRAIN: begin
          m_drain_elapsed++;
          if (!want_pause) begin m_mode = RELEASE; m_guard_left = TB_GUARD; end
          else if (halt_ack || m_drain_elapsed >= TB_ACK) m_mode = HALT;
        end
        HALT: begin
          if (hs_req) m_mode = HS;
          else if (!want_pause) begin m_mode = RELEASE; m_guard_left = TB_GUARD; end
        end
        HS: if (!hs_req) m_mode = HALT;
        default: begin
          m_guard_left--;
          if (want_pause) begin m_mode = DRAIN; m_drain_elapsed = 0; end
          else if (m_guard_left == 0) m_mode = RUN;
        end
      endcase
      if (!m_user) m_paused_cycles = 0;
      else if (m_paused_cycles < 1000000) m_paused_cycles++;
      if (btn_pause && !m_btn_prev) m_user = !m_user;
      m_btn_prev = btn_pause;
    end
  end

  always @(negedge clk_sys) begin
    if (chk_en) begin
      check_eq("state", int'(state), m_mode);
      check_eq("pause", int'(pause), int'(m_mode != RUN));
      check_eq("hs_grant", int'(hs_grant), int'(m_mode == HS));
      check_eq("user_paused", int'(user_paused), int'(m_user));
      check_eq("dim_video", int'(dim_video), int'(DIM_ON && m_paused_cycles >= TB_DIM));
      check_eq("grant_without_pause", int'(hs_grant && !pause), 0);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  initial begin
    // Reset with the button held: no toggle on release.
    step(3);
    reset = 1'b0;
    chk_en = 1'b1;
    step(2);
    check_eq("rst_user", int'(user_paused), 0);
    check_eq("rst_state", int'(state), RUN);
    btn_pause = 1'b0;
    step(1);
    btn_pause = 1'b1;
    step(1);
    check_eq("press_user", int'(user_paused), 1);
    check_eq("press_pause_early", int'(pause), 0);
    step(1);
    check_eq("press_pause", int'(pause), 1);
    btn_pause = 1'b0;
    // Dim threshold: paused count is (steps since press - 1).
    step(98);
    check_eq("dim_before", int'(dim_video), 0);
    step(1);
    check_eq("dim_at", int'(dim_video), int'(DIM_ON));
    step(20);
    check_eq("dim_hold", int'(dim_video), int'(DIM_ON));
    check_eq("user_halt", int'(state), HALT);
    btn_pause = 1'b1;
    step(1);
    check_eq("unpause_user", int'(user_paused), 0);
    step(1);
    check_eq("dim_off", int'(dim_video), 0);
    btn_pause = 1'b0;
    step(8);
    check_eq("back_run", int'(state), RUN);

    // Grant with ack already high.
    hs_req = 1'b1;
    step(1); check_eq("hs_drain", int'(state), DRAIN);
    step(1); check_eq("hs_grant_n2", int'(hs_grant), 0);
    step(1); check_eq("hs_grant_n3", int'(hs_grant), 1);
    hs_req = 1'b0;
    step(1); check_eq("hs_drop", int'(hs_grant), 0);
    check_eq("hs_drop_state", int'(state), HALT);
    step(1); check_eq("hs_release", int'(state), RELEASE);
    step(3); check_eq("guard_pause", int'(pause), 1);
    step(1); check_eq("guard_done", int'(pause), 0);

    // Ack timeout, then reset while granted.
    halt_ack = 1'b0;
    hs_req = 1'b1;
    step(1);
    step(15); check_eq("tmo_drain", int'(state), DRAIN);
    step(1);  check_eq("tmo_halt", int'(state), HALT);
    step(1);  check_eq("tmo_hs", int'(state), HS);
    reset = 1'b1;
    step(1);
    check_eq("rst_hs_grant", int'(hs_grant), 0);
    check_eq("rst_hs_pause", int'(pause), 0);
    check_eq("rst_hs_state", int'(state), RUN);
    reset = 1'b0;
    hs_req = 1'b0;
    halt_ack = 1'b1;
    step(2);

    // OSD pause gating and re-drain from RELEASE.
    osd_open = 1'b1;
    step(5); check_eq("osd_noen", int'(pause), 0);
    osd_pause_en = 1'b1;
    step(1); check_eq("osd_drain", int'(state), DRAIN);
    step(1); check_eq("osd_halt", int'(state), HALT);
    osd_open = 1'b0;
    step(1); check_eq("osd_release", int'(state), RELEASE);
    step(1);
    osd_open = 1'b1;
    step(1); check_eq("osd_redrain", int'(state), DRAIN);
    osd_open = 1'b0;
    step(10); check_eq("osd_run", int'(state), RUN);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) btn_pause = ~btn_pause;
      if ($urandom_range(0, 31) == 0) osd_open = ~osd_open;
      if ($urandom_range(0, 63) == 0) osd_pause_en = ~osd_pause_en;
      if ($urandom_range(0, 23) == 0) hs_req = ~hs_req;
      halt_ack = ($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 499) == 0);
      step(1);
    end
    reset = 1'b0;
    step(2);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pause_arbiter.md
# pause_arbiter

Sequences the game-core pause line and arbitrates work RAM between the running CPU and the high-score save/restore engine. Merges three pause sources: user pause button, OSD-open pause, high-score RAM request. Grants the high-score engine RAM only after the core has quiesced, and holds the core halted for a guard interval after the grant is released. Sits in the emu top level between `hps_io`/joystick decode, the `hiscore` module and the `galaga` core, and also produces the screen-dim flag for long user pauses.

## Interface
Parameters:
- `DIM_CYCLES`, default 32'h0ABA9500: cycles of continuous user pause before dimming (10 s at 18 MHz).
- `ACK_TIMEOUT`, default 16: maximum number of cycles spent in DRAIN waiting for `halt_ack`; range 1–255.
- `GUARD`, default 4: number of cycles spent in RELEASE before resuming; range 1–15.

Ports (single clock domain; reset is synchronous, active-high):
- `clk_sys`  in  1  system clock.
- `reset`  in  1  synchronous active-high reset.
- `btn_pause`  in  1  raw pause button level; the block detects rising edges.
- `osd_open`  in  1  OSD currently displayed.
- `osd_pause_en`  in  1  1 = pause while the OSD is open.
- `hs_req`  in  1  high-score engine requests RAM; held high until it is finished.
- `halt_ack`  in  1  core reports the CPU is halted.
- `pause`  out  1  halt request to the core.
- `hs_grant`  out  1  high-score engine owns RAM.
- `dim_video`  out  1  halve the RGB output.
- `user_paused`  out  1  user pause toggle state.
- `state`  out  3  FSM state, for debug.

## Operation
- Edge detector: `btn_prev` resets to 1, so a button held through reset does not toggle. A rising edge (`btn_pause & ~btn_prev`) toggles `user_paused`.
- Pause source: `pause_src = user_paused | (osd_open & osd_pause_en) | hs_req`.
- FSM states and encodings:
  - RUN = 0: if `pause_src` → DRAIN, and `tmo` is cleared.
  - DRAIN = 1: `tmo` increments. Exit rules, in priority order:
    - `!pause_src` → RELEASE.
    - `halt_ack` → HALT.
    - `tmo == ACK_TIMEOUT-1` → HALT. A timeout is not an error.
  - HALT = 2: if `hs_req` → HS; else if `!pause_src` → RELEASE.
  - HS = 3: `hs_grant` is 1. If `!hs_req` → HALT. The HS-to-RELEASE path always passes through HALT.
  - RELEASE = 4: `gcnt` increments. Exit rules:
    - `pause_src` → DRAIN, with `tmo` cleared; the core is re-drained.
    - `gcnt == GUARD-1` → RUN.
- Outputs are Moore, decoded from the state register:
  - `pause` = (state != RUN).
  - `hs_grant` = (state == HS).
  - `state` = encoding above.
- Dim counter, 32-bit:
  - Cleared whenever `user_paused` = 0.
  - Otherwise increments, saturating at `DIM_CYCLES`.
  - `dim_video` = (`dimcnt >= DIM_CYCLES`).
  - OSD and high-score pauses never dim the screen.
- Reset: state = RUN, and `tmo`, `gcnt`, `dimcnt`, `user_paused` = 0, `btn_prev` = 1. All outputs are 0 after the reset edge, including a reset during HS (the grant drops immediately).

## Timing
- Registered output latency: `pause_src` rising at edge n gives `pause` = 1 after edge n+1.
- Minimum request-to-grant latency, starting from RUN:
  - `hs_req` high before edge n gives DRAIN at n+1.
  - With `halt_ack` already high, HALT at n+2 and HS at n+3 (`hs_grant` = 1).
  - With no ack, `hs_grant` rises at n+2+`ACK_TIMEOUT`.
- Grant release: `hs_req` low before edge m gives `hs_grant` = 0 after m+1 (state HALT).
- Resume after grant release: if no other source is active, RELEASE at m+2 and RUN at m+2+`GUARD`, so `pause` = 0 from m+2+`GUARD`.
- Simultaneous events:
  - Button edge and `hs_req` in the same cycle: both are honoured. `user_paused` toggles and the FSM proceeds with the grant. After HS, the FSM stays in HALT while `user_paused` = 1.
  - A toggle-off while in HS has no effect on the grant.
- `hs_grant` is never 1 while `pause` is 0.

## Configuration
- `PAUSE_DIM_EN` defined: the dim counter is built and `dim_video` behaves as specified above.
- Not defined: no counter is built, `dim_video` is tied to 0 and `DIM_CYCLES` is unused. All other behaviour is identical.

## Test plan
- Reset held with `btn_pause` = 1, then released → `user_paused` stays 0 and state = RUN. Releasing and re-pressing the button → `user_paused` = 1 and `pause` = 1 two cycles after the press edge.
- `hs_req` = 1 in RUN with `halt_ack` tied 1 → `hs_grant` = 1 exactly 3 cycles later. Dropping `hs_req` → grant falls in 1 cycle and `pause` falls `GUARD`+1 cycles later.
- `hs_req` with `halt_ack` tied 0 and `ACK_TIMEOUT` = 16 → state stays DRAIN for 16 cycles, then HALT, then HS on the next cycle.
- `osd_open` = 1 with `osd_pause_en` = 0 → `pause` stays 0. Setting `osd_pause_en` = 1 → `pause` = 1. Closing the OSD at cycle 2 of RELEASE's countdown, then reopening during RELEASE → state returns to DRAIN, not RUN.
- With `PAUSE_DIM_EN` defined and `DIM_CYCLES` = 100, user pause on → `dim_video` = 1 after 100 cycles and stays 1. Toggling the pause off → `dim_video` = 0 one cycle later. Without the macro, `dim_video` stays 0 throughout.
- Assert `reset` while in HS → `hs_grant` = 0, `pause` = 0 and state = 0 after one edge. Continuous check: `hs_grant` & !`pause` is never true.
